// File: rtl/isa_pkg.sv
// Shared ISA definitions for fetch, decode and execute.
// Field positions, opcodes and the combinational field decoder.
package isa_pkg;

  localparam int IW   = 24;
  localparam int NREG = 16;
  localparam int RW   = 4;

  localparam int OP_HI  = 23;
  localparam int OP_LO  = 20;
  localparam int RD_HI  = 19;
  localparam int RD_LO  = 16;
  localparam int RS1_HI = 15;
  localparam int RS1_LO = 12;
  localparam int RS2_HI = 11;
  localparam int RS2_LO = 8;
  localparam int IMM_HI = 7;
  localparam int IMM_LO = 0;

  localparam logic [3:0] OP_NOP   = 4'h0;
  localparam logic [3:0] OP_ADD   = 4'h1;
  localparam logic [3:0] OP_SUB   = 4'h2;
  localparam logic [3:0] OP_AND   = 4'h3;
  localparam logic [3:0] OP_OR    = 4'h4;
  localparam logic [3:0] OP_XOR   = 4'h5;
  localparam logic [3:0] OP_ADDI  = 4'h6;
  localparam logic [3:0] OP_LOAD  = 4'h7;
  localparam logic [3:0] OP_STORE = 4'h8;
  localparam logic [3:0] OP_BEQ   = 4'h9;
  localparam logic [3:0] OP_JMP   = 4'hA;
  localparam logic [3:0] OP_HALT  = 4'hF;

  typedef struct packed {
    logic [3:0]    opcode;
    logic [RW-1:0] rd;
    logic [RW-1:0] rs1;
    logic [RW-1:0] rs2;
    logic [15:0]   imm;
    logic          use_imm;
    logic          writes_rd;
    logic          illegal;
    logic          src1;
    logic          src2;
    logic          halt;
  } dec_t;

  function automatic dec_t decode(
    input logic [IW-1:0] w
  );
    dec_t d;
    logic wr;
    logic s1;
    logic s2;
    d = '0;
    wr = 1'b0;
    s1 = 1'b0;
    s2 = 1'b0;
    d.opcode = w[OP_HI:OP_LO];
    d.rd     = w[RD_HI:RD_LO];
    d.rs1    = w[RS1_HI:RS1_LO];
    d.rs2    = w[RS2_HI:RS2_LO];
    d.imm    = {{8{w[IMM_HI]}},
                w[IMM_HI:IMM_LO]};
    unique case (d.opcode)
      OP_ADD, OP_SUB, OP_AND,
      OP_OR, OP_XOR: begin
        wr = 1'b1;
        s1 = 1'b1;
        s2 = 1'b1;
      end
      OP_ADDI, OP_LOAD: begin
        wr = 1'b1;
        s1 = 1'b1;
        d.use_imm = 1'b1;
      end
      OP_STORE, OP_BEQ: begin
        s1 = 1'b1;
        s2 = 1'b1;
        d.use_imm = 1'b1;
      end
      OP_JMP: d.use_imm = 1'b1;
      OP_HALT: d.halt = 1'b1;
      OP_NOP: ;
      default: d.illegal = 1'b1;
    endcase
    // r0 is hardwired: never reserved, never a hazard
    d.writes_rd = wr && (d.rd != '0);
    d.src1 = s1 && (d.rs1 != '0);
    d.src2 = s2 && (d.rs2 != '0);
    return d;
  endfunction

endpackage

// File: rtl/decode_unit_if.sv
// Fetch, execute and writeback signals around the decode stage.
// master drives stimulus side, slave is the decode stage.
interface decode_unit_if #(
  parameter int IW = isa_pkg::IW
) ();

  logic          instr_valid;
  logic [IW-1:0] instruction;
  logic          instr_ready;
  logic          exe_ready;
  logic          flush;
  logic          wb_valid;
  logic [3:0]    wb_rd;
  logic          dec_valid;
  logic [3:0]    dec_opcode;
  logic [3:0]    dec_rd;
  logic [3:0]    dec_rs1;
  logic [3:0]    dec_rs2;
  logic [15:0]   dec_imm;
  logic          dec_use_imm;
  logic          dec_writes_rd;
  logic          dec_illegal;
  logic          halted;

  modport master (
    output instr_valid,
    output instruction,
    output exe_ready,
    output flush,
    output wb_valid,
    output wb_rd,
    input  instr_ready,
    input  dec_valid,
    input  dec_opcode,
    input  dec_rd,
    input  dec_rs1,
    input  dec_rs2,
    input  dec_imm,
    input  dec_use_imm,
    input  dec_writes_rd,
    input  dec_illegal,
    input  halted
  );

  modport slave (
    input  instr_valid,
    input  instruction,
    input  exe_ready,
    input  flush,
    input  wb_valid,
    input  wb_rd,
    output instr_ready,
    output dec_valid,
    output dec_opcode,
    output dec_rd,
    output dec_rs1,
    output dec_rs2,
    output dec_imm,
    output dec_use_imm,
    output dec_writes_rd,
    output dec_illegal,
    output halted
  );

endinterface

// File: rtl/decode_unit_scoreboard.sv
// Register busy bits: set on issue, cleared by writeback or flush.
// Queries see a same-cycle writeback as already complete.
module scoreboard #(
  parameter int NREG = 16,
  parameter int RW   = 4
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          set_en,
  input  logic [RW-1:0] set_idx,
  input  logic          clr_en,
  input  logic [RW-1:0] clr_idx,
  input  logic          fl_en,
  input  logic [RW-1:0] fl_idx,
  input  logic [RW-1:0] q1_idx,
  input  logic [RW-1:0] q2_idx,
  output logic          q1_busy,
  output logic          q2_busy
);

  logic [NREG-1:0] busy;
  logic [NREG-1:0] set_m;
  logic [NREG-1:0] clr_m;
  logic [NREG-1:0] fl_m;

  always_comb begin
    set_m = '0;
    clr_m = '0;
    fl_m  = '0;
    if (set_en) set_m[set_idx] = 1'b1;
    if (clr_en) clr_m[clr_idx] = 1'b1;
    if (fl_en)  fl_m[fl_idx]   = 1'b1;
  end

  // a new reservation outranks a writeback to the same register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      busy <= '0;
    end else begin
      busy <= (busy & ~clr_m & ~fl_m)
            | set_m;
    end
  end

  assign q1_busy = busy[q1_idx]
                 & ~clr_m[q1_idx];
  assign q2_busy = busy[q2_idx]
                 & ~clr_m[q2_idx];

endmodule

// File: rtl/decode_unit.sv
// Decode stage: field split, RAW interlock and one output register.
// HALT latches a sticky stop; flush drops the held instruction.
module decode_unit
  import isa_pkg::*;
#(
  parameter int IW   = isa_pkg::IW,
  parameter int NREG = isa_pkg::NREG
) (
  input logic          clk,
  input logic          reset,
  decode_unit_if.slave bus
);

  logic [IW-1:0] word;
  dec_t          d;
  logic          b1;
  logic          b2;
  logic          hazard;
  logic          ready;
  logic          accept;

  logic        dv_q;
  logic [3:0]  op_q;
  logic [3:0]  rd_q;
  logic [3:0]  rs1_q;
  logic [3:0]  rs2_q;
  logic [15:0] imm_q;
  logic        ui_q;
  logic        wr_q;
  logic        ill_q;
  logic        hlt_q;

  assign word = bus.instruction;
  assign d    = decode(word);

  scoreboard #(
    .NREG (NREG),
    .RW   (RW)
  ) u_sb (
    .clk     (clk),
    .reset   (reset),
    .set_en  (accept && d.writes_rd),
    .set_idx (d.rd),
    .clr_en  (bus.wb_valid),
    .clr_idx (bus.wb_rd),
    .fl_en   (bus.flush && dv_q && wr_q),
    .fl_idx  (rd_q),
    .q1_idx  (d.rs1),
    .q2_idx  (d.rs2),
    .q1_busy (b1),
    .q2_busy (b2)
  );

  assign hazard = (d.src1 && b1)
               || (d.src2 && b2);

  assign ready = (!dv_q || bus.exe_ready)
              && !hazard
              && !hlt_q
              && !bus.flush;

  assign accept = bus.instr_valid && ready;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      dv_q  <= 1'b0;
      op_q  <= '0;
      rd_q  <= '0;
      rs1_q <= '0;
      rs2_q <= '0;
      imm_q <= '0;
      ui_q  <= 1'b0;
      wr_q  <= 1'b0;
      ill_q <= 1'b0;
      hlt_q <= 1'b0;
    end else begin
      if (bus.flush) begin
        dv_q <= 1'b0;
      end else if (accept) begin
        dv_q  <= 1'b1;
        op_q  <= d.opcode;
        rd_q  <= d.rd;
        rs1_q <= d.rs1;
        rs2_q <= d.rs2;
        imm_q <= d.imm;
        ui_q  <= d.use_imm;
        wr_q  <= d.writes_rd;
        ill_q <= d.illegal;
      end else if (bus.exe_ready) begin
        dv_q <= 1'b0;
      end
      if (accept && d.halt) hlt_q <= 1'b1;
    end
  end

  assign bus.instr_ready   = ready;
  assign bus.dec_valid     = dv_q;
  assign bus.dec_opcode    = op_q;
  assign bus.dec_rd        = rd_q;
  assign bus.dec_rs1       = rs1_q;
  assign bus.dec_rs2       = rs2_q;
  assign bus.dec_imm       = imm_q;
  assign bus.dec_use_imm   = ui_q;
  assign bus.dec_writes_rd = wr_q;
  assign bus.dec_illegal   = ill_q;
  assign bus.halted        = hlt_q;

endmodule

// File: tb/tb_decode_unit.sv
// Bench for decode_unit: vector table plus interlock/flush/halt sequences.
// Expected records queue on accept and are compared on consumption.
module tb_decode_unit;

  typedef struct packed {
    logic [3:0]  op;
    logic [3:0]  rd;
    logic [3:0]  rs1;
    logic [3:0]  rs2;
    logic [15:0] imm;
    logic        ui;
    logic        wr;
    logic        ill;
  } exp_t;

  typedef struct {
    logic [23:0] ins;
    exp_t        e;
  } vec_t;

  logic clk = 1'b0;
  logic reset = 1'b1;
  int total = 0;
  int bad = 0;
  exp_t q[$];
  exp_t cur;
  vec_t tbl[14];

  decode_unit_if bus ();

  decode_unit dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1);
  end

  function automatic exp_t mk(
    input logic [3:0] op, rd, rs1, rs2,
    input logic [15:0] imm,
    input logic ui, wr, ill
  );
    exp_t e;
    e.op = op; e.rd = rd;
    e.rs1 = rs1; e.rs2 = rs2;
    e.imm = imm; e.ui = ui;
    e.wr = wr; e.ill = ill;
    return e;
  endfunction

  function automatic exp_t got();
    exp_t e;
    e.op  = bus.dec_opcode;
    e.rd  = bus.dec_rd;
    e.rs1 = bus.dec_rs1;
    e.rs2 = bus.dec_rs2;
    e.imm = bus.dec_imm;
    e.ui  = bus.dec_use_imm;
    e.wr  = bus.dec_writes_rd;
    e.ill = bus.dec_illegal;
    return e;
  endfunction

  task automatic chk(input string n,
                     input logic [63:0] a,
                     input logic [63:0] x);
    total++;
    if (a !== x) begin
      bad++;
      $display("FAIL %s: got %h want %h",
               n, a, x);
    end
  endtask

  always @(negedge clk) begin
    if (!reset) begin
      if (bus.dec_valid &&
          (bus.exe_ready || bus.flush)) begin
        if (q.size() == 0) begin
          chk("unexpected_out", 1, 0);
        end else begin
          exp_t e;
          e = q.pop_front();
          if (!bus.flush)
            chk("dec_fields", got(), e);
        end
      end
      if (bus.instr_valid && bus.instr_ready)
        q.push_back(cur);
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic present(input logic [23:0] ins,
                         input exp_t e);
    bus.instruction = ins;
    cur = e;
    bus.instr_valid = 1'b1;
  endtask

  task automatic send(input logic [23:0] ins,
                      input exp_t e);
    bit ok;
    ok = 0;
    present(ins, e);
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (bus.instr_ready) begin
        ok = 1;
        break;
      end
    end
    if (!ok) chk("accept_timeout", 0, 1);
    tick();
    bus.instr_valid = 1'b0;
    bus.instruction = '0;
  endtask

  task automatic wb(input logic [3:0] r);
    bus.wb_valid = 1'b1;
    bus.wb_rd = r;
    tick();
    bus.wb_valid = 1'b0;
    bus.wb_rd = '0;
  endtask

  initial begin
    tbl[0]  = '{24'h112300, mk(4'h1, 4'h1, 4'h2, 4'h3, 16'h0000, 0, 1, 0)};
    tbl[1]  = '{24'h6410FF, mk(4'h6, 4'h4, 4'h1, 4'h0, 16'hFFFF, 1, 1, 0)};
    tbl[2]  = '{24'h20A57F, mk(4'h2, 4'h0, 4'hA, 4'h5, 16'h007F, 0, 0, 0)};
    tbl[3]  = '{24'h3FED80, mk(4'h3, 4'hF, 4'hE, 4'hD, 16'hFF80, 0, 1, 0)};
    tbl[4]  = '{24'h421101, mk(4'h4, 4'h2, 4'h1, 4'h1, 16'h0001, 0, 1, 0)};
    tbl[5]  = '{24'h533300, mk(4'h5, 4'h3, 4'h3, 4'h3, 16'h0000, 0, 1, 0)};
    tbl[6]  = '{24'h765010, mk(4'h7, 4'h6, 4'h5, 4'h0, 16'h0010, 1, 1, 0)};
    tbl[7]  = '{24'h8765F0, mk(4'h8, 4'h7, 4'h6, 4'h5, 16'hFFF0, 1, 0, 0)};
    tbl[8]  = '{24'h9012FE, mk(4'h9, 4'h0, 4'h1, 4'h2, 16'hFFFE, 1, 0, 0)};
    tbl[9]  = '{24'hA00040, mk(4'hA, 4'h0, 4'h0, 4'h0, 16'h0040, 1, 0, 0)};
    tbl[10] = '{24'h012345, mk(4'h0, 4'h1, 4'h2, 4'h3, 16'h0045, 0, 0, 0)};
    tbl[11] = '{24'hB10000, mk(4'hB, 4'h1, 4'h0, 4'h0, 16'h0000, 0, 0, 1)};
    tbl[12] = '{24'hE20000, mk(4'hE, 4'h2, 4'h0, 4'h0, 16'h0000, 0, 0, 1)};
    tbl[13] = '{24'hD56781, mk(4'hD, 4'h5, 4'h6, 4'h7, 16'hFF81, 0, 0, 1)};

    bus.instr_valid = 1'b0;
    bus.instruction = '0;
    bus.exe_ready = 1'b1;
    bus.flush = 1'b0;
    bus.wb_valid = 1'b0;
    bus.wb_rd = '0;
    cur = '0;

    repeat (3) @(posedge clk);
    #1;
    chk("rst_dec_valid", bus.dec_valid, 0);
    chk("rst_halted", bus.halted, 0);
    chk("rst_fields", got(), 0);
    reset = 1'b0;

    for (int i = 0; i < 14; i++) begin
      send(tbl[i].ins, tbl[i].e);
      if (i == 0) begin
        @(negedge clk);
        chk("lat1_dec_valid", bus.dec_valid, 1);
      end
      if (tbl[i].e.wr) wb(tbl[i].e.rd);
    end

    // read-after-write interlock with writeback bypass
    send(24'h112300, mk(4'h1, 4'h1, 4'h2, 4'h3, 16'h0000, 0, 1, 0));
    present(24'h6410FF, mk(4'h6, 4'h4, 4'h1, 4'h0, 16'hFFFF, 1, 1, 0));
    repeat (3) begin
      @(negedge clk);
      chk("raw_stall_ready", bus.instr_ready, 0);
    end
    tick();
    bus.wb_valid = 1'b1;
    bus.wb_rd = 4'h1;
    @(negedge clk);
    chk("raw_bypass_ready", bus.instr_ready, 1);
    tick();
    bus.wb_valid = 1'b0;
    bus.instr_valid = 1'b0;
    @(negedge clk);
    chk("raw_imm", bus.dec_imm, 16'hFFFF);
    tick();
    wb(4'h4);

    // backpressure holds the output register
    bus.exe_ready = 1'b0;
    send(24'h8765F0, mk(4'h8, 4'h7, 4'h6, 4'h5, 16'hFFF0, 1, 0, 0));
    present(24'h9012FE, mk(4'h9, 4'h0, 4'h1, 4'h2, 16'hFFFE, 1, 0, 0));
    repeat (3) begin
      @(negedge clk);
      chk("stall_ready", bus.instr_ready, 0);
      chk("stall_valid", bus.dec_valid, 1);
      chk("stall_hold", got(),
          mk(4'h8, 4'h7, 4'h6, 4'h5, 16'hFFF0, 1, 0, 0));
    end
    tick();
    bus.exe_ready = 1'b1;
    @(negedge clk);
    chk("stall_release_ready", bus.instr_ready, 1);
    tick();
    bus.instr_valid = 1'b0;
    tick();

    // flush drops ADD r5 and its reservation
    bus.exe_ready = 1'b0;
    send(24'h152300, mk(4'h1, 4'h5, 4'h2, 4'h3, 16'h0000, 0, 1, 0));
    bus.flush = 1'b1;
    @(negedge clk);
    chk("flush_ready", bus.instr_ready, 0);
    tick();
    bus.flush = 1'b0;
    bus.exe_ready = 1'b1;
    @(negedge clk);
    chk("flush_dec_valid", bus.dec_valid, 0);
    tick();
    present(24'h215000, mk(4'h2, 4'h1, 4'h5, 4'h0, 16'h0000, 0, 1, 0));
    @(negedge clk);
    chk("flush_r5_free", bus.instr_ready, 1);
    tick();
    bus.instr_valid = 1'b0;
    wb(4'h1);

    // same-cycle set and clear keeps the bit set
    present(24'h160000, mk(4'h1, 4'h6, 4'h0, 4'h0, 16'h0000, 0, 1, 0));
    bus.wb_valid = 1'b1;
    bus.wb_rd = 4'h6;
    @(negedge clk);
    chk("setclr_accept", bus.instr_ready, 1);
    tick();
    bus.wb_valid = 1'b0;
    present(24'h216000, mk(4'h2, 4'h1, 4'h6, 4'h0, 16'h0000, 0, 1, 0));
    @(negedge clk);
    chk("setclr_stall", bus.instr_ready, 0);
    tick();
    wb(4'h6);
    bus.instr_valid = 1'b0;
    wb(4'h1);

    // illegal opcode leaves the scoreboard alone
    send(24'hC70000, mk(4'hC, 4'h7, 4'h0, 4'h0, 16'h0000, 0, 0, 1));
    present(24'h117000, mk(4'h1, 4'h1, 4'h7, 4'h0, 16'h0000, 0, 1, 0));
    @(negedge clk);
    chk("illegal_no_sb", bus.instr_ready, 1);
    tick();
    bus.instr_valid = 1'b0;
    wb(4'h1);

    // reset in the middle of a stall
    bus.exe_ready = 1'b0;
    send(24'h8765F0, mk(4'h8, 4'h7, 4'h6, 4'h5, 16'hFFF0, 1, 0, 0));
    @(negedge clk);
    #2;
    reset = 1'b1;
    q.delete();
    #1;
    chk("midrst_dec_valid", bus.dec_valid, 0);
    chk("midrst_fields", got(), 0);
    tick();
    reset = 1'b0;
    bus.exe_ready = 1'b1;
    present(24'h9012FE, mk(4'h9, 4'h0, 4'h1, 4'h2, 16'hFFFE, 1, 0, 0));
    @(negedge clk);
    chk("postrst_ready", bus.instr_ready, 1);
    tick();
    bus.instr_valid = 1'b0;
    @(negedge clk);
    chk("postrst_valid", bus.dec_valid, 1);
    tick();

    // HALT issues once then blocks fetch
    send(24'hF00000, mk(4'hF, 4'h0, 4'h0, 4'h0, 16'h0000, 0, 0, 0));
    present(24'h112300, mk(4'h1, 4'h1, 4'h2, 4'h3, 16'h0000, 0, 1, 0));
    repeat (5) begin
      @(negedge clk);
      chk("halt_ready", bus.instr_ready, 0);
      chk("halt_sticky", bus.halted, 1);
    end
    tick();
    bus.instr_valid = 1'b0;
    bus.instruction = '0;
    reset = 1'b1;
    #1;
    chk("halt_rst_halted", bus.halted, 0);
    chk("halt_rst_ready", bus.instr_ready, 1);
    tick();
    reset = 1'b0;
    @(negedge clk);
    chk("queue_empty", q.size(), 0);

    $display("test done: total=%0d bad=%0d",
             total, bad);
    $finish;
  end

endmodule
